func_sweep_ctrl: RTL
====================

Name: func_sweep_ctrl

Overview:
- Sequencer for the team's 4-input function implementations: ROM/PLA, transistor MDNF, primitive/assign, Zhegalkin, Pierce, Sheffer, UDP and buffered UDP.
- Drives the shared input vector x through all 16 codes and enables the buffered-output lane.
- Samples every implementation's output after a settle window and compares each against a programmable 16-bit truth table.
- Reports a per-lane error mask, a fail count, the first failing vector and pass/done status. Replaces the hand-read comparison table in the bench with a self-checking engine.

Parameters:
- N_IMPL, 10, number of implementation outputs on y.
- SETTLE, 1, cycles x is held before sampling; legal range 1..15.
- TT_RST, 16'h0AC5, truth table after reset; bit i is the expected output for x==i (minterms 0,2,6,7,9,11).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a sweep; honoured only in IDLE.
- abort  input  1  cancel the sweep in progress.
- tt_load  input  1  load tt_in into the truth-table register; honoured only when busy==0.
- tt_in  input  16  new truth table.
- y  input  N_IMPL  implementation outputs; bit k is lane k.
- x  output  4  vector driven to all implementations.
- oe  output  1  enable for the buffered lane (bufif1 control).
- busy  output  1  sweep in progress.
- done  output  1  one-cycle pulse at sweep completion.
- pass  output  1  last completed sweep had no mismatches.
- err_mask  output  N_IMPL  sticky per-lane mismatch flags.
- fail_cnt  output  5  number of vectors (0..16) with at least one mismatching lane.
- first_fail_x  output  4  x of the first mismatching vector.
- first_fail_valid  output  1  first_fail_x is meaningful.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. Nothing is sampled asynchronously.
- Reset values: x=0, oe=0, busy=0, done=0, pass=0, err_mask=0, fail_cnt=0, first_fail_x=0, first_fail_valid=0, tt=TT_RST, state=IDLE, settle counter=0.
- State IDLE:
  - If tt_load, then tt<=tt_in.
  - If start, then clear err_mask, fail_cnt, first_fail_valid and pass; set x<=0, oe<=1, busy<=1; go to DRIVE.
  - If start and tt_load fire in the same cycle, the sweep uses the new tt_in.
- State DRIVE: hold x; count SETTLE cycles; then go to SAMPLE.
- State SAMPLE (1 cycle):
  - mism[k] = (y[k] !== tt[x]); X or Z on y counts as a mismatch.
  - err_mask <= err_mask | mism.
  - If |mism: fail_cnt+1. If first_fail_valid==0, also first_fail_x<=x and first_fail_valid<=1.
  - If x==15, go to DONE. Otherwise x<=x+1 (no wrap past 15) and go to DRIVE.
- State DONE (1 cycle):
  - done=1, busy=0, oe=0, x<=0.
  - pass <= (err_mask after the final sample == 0).
  - Go to IDLE.
- Latency: with start sampled at edge k, busy is high for cycles k+1..k+16*(SETTLE+1). done is high for exactly one cycle, the next one. With SETTLE=1: busy is high for 32 cycles and done is at k+33.
- The first vector x=0 is on the outputs in the cycle busy first rises.
- start while busy: ignored. tt_load while busy: ignored; tt is stable for the whole sweep.
- abort while busy: go to IDLE at the next edge; busy=0, oe=0, x=0, no done pulse, pass=0. err_mask, fail_cnt and first_fail are held at their partial values. abort in IDLE has no effect.
- abort and start in the same IDLE cycle: start wins.
- rst mid-sweep: all outputs return to reset values at the next edge, including tt=TT_RST. No done pulse.
- fail_cnt saturation is not required; the maximum reachable value is 16, which fits in 5 bits.
- Results persist in IDLE until the next start or rst.

Test Plan:
- Reset, start with SETTLE=1, every lane driven by a golden model of 16'h0AC5 -> x steps 0..15, done at start+33, pass=1, err_mask=0, fail_cnt=0, first_fail_valid=0.
- Lane 3 stuck at 0, others golden -> err_mask=0x008, fail_cnt=6, first_fail_x=0, pass=0.
- tt_load 16'hFFFF together with start, lanes still golden for 0x0AC5 -> err_mask all ones, fail_cnt=10, first_fail_x=1, pass=0. A second sweep after tt_load 16'h0AC5 -> pass=1.
- Lane 9 (buffered lane) reading X whenever oe=0, otherwise golden -> pass=1. oe is high throughout busy and low in IDLE/DONE.
- abort asserted while x==5 -> next cycle busy=0, oe=0, x=0, no done; a start pulse during the sweep before the abort is ignored (x sequence unchanged).
- rst asserted at x==9 after a lane-0 failure -> next cycle err_mask=0, fail_cnt=0, tt=0x0AC5, state IDLE. A new start completes with pass=1.

Source files
------------

// File: rtl/func_sweep_ctrl.sv
// func_sweep_ctrl: sweeps a 4-bit vector x through all 16 codes, waits SETTLE
// cycles per code, then compares every implementation lane on y against the
// programmable truth table. Reports sticky per-lane errors, a failing-vector
// count, the first failing vector and pass/done status.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   start, abort      begin a sweep (IDLE only) / cancel a running sweep
//   tt_load, tt_in    load a new truth table while not busy
//   y                 implementation outputs, bit k is lane k
//   x, oe             vector under test, enable for the buffered lane
//   busy, done, pass  sweep running, completion pulse, last sweep clean
//   err_mask          sticky per-lane mismatch flags
//   fail_cnt          number of vectors with at least one mismatching lane
//   first_fail_x/_valid  first mismatching vector and its qualifier
module func_sweep_ctrl #(
    parameter int unsigned N_IMPL = 10,
    parameter int unsigned SETTLE = 1,
    parameter logic [15:0] TT_RST = 16'h0AC5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              tt_load,
    input  logic [15:0]       tt_in,
    input  logic [N_IMPL-1:0] y,
    output logic [3:0]        x,
    output logic              oe,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IMPL-1:0] err_mask,
    output logic [4:0]        fail_cnt,
    output logic [3:0]        first_fail_x,
    output logic              first_fail_valid
);

    localparam int unsigned X_W    = 4;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned FCNT_W = 5;
    localparam int unsigned TT_W   = 16;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [X_W-1:0]      x_q, x_d;
    logic                oe_q, oe_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [N_IMPL-1:0]   err_mask_q, err_mask_d;
    logic [FCNT_W-1:0]   fail_cnt_q, fail_cnt_d;
    logic [X_W-1:0]      ff_x_q, ff_x_d;
    logic                ff_valid_q, ff_valid_d;
    logic [TT_W-1:0]     tt_q, tt_d;
    logic [N_IMPL-1:0]   mism_c;

    // Per-lane mismatch; case inequality so X/Z on a lane counts as a failure
    always_comb begin
        for (int k = 0; k < N_IMPL; k++) begin
            mism_c[k] = (y[k] !== tt_q[x_q]);
        end
    end

    // State and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            x_q        <= '0;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_mask_q <= '0;
            fail_cnt_q <= '0;
            ff_x_q     <= '0;
            ff_valid_q <= 1'b0;
            tt_q       <= TT_RST;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            x_q        <= x_d;
            oe_q       <= oe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            err_mask_q <= err_mask_d;
            fail_cnt_q <= fail_cnt_d;
            ff_x_q     <= ff_x_d;
            ff_valid_q <= ff_valid_d;
            tt_q       <= tt_d;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        x_d        = x_q;
        oe_d       = oe_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        err_mask_d = err_mask_q;
        fail_cnt_d = fail_cnt_q;
        ff_x_d     = ff_x_q;
        ff_valid_d = ff_valid_q;
        tt_d       = tt_q;

        unique case (state_q)
            IDLE: begin
                if (tt_load) begin
                    tt_d = tt_in;
                end
                if (start) begin
                    err_mask_d = '0;
                    fail_cnt_d = '0;
                    ff_valid_d = 1'b0;
                    pass_d     = 1'b0;
                    x_d        = '0;
                    cnt_d      = '0;
                    oe_d       = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = DRIVE;
                end
            end

            DRIVE: begin
                if (cnt_q == CNT_W'(SETTLE - 1)) begin
                    cnt_d   = '0;
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            SAMPLE: begin
                err_mask_d = err_mask_q | mism_c;
                if (|mism_c) begin
                    fail_cnt_d = fail_cnt_q + FCNT_W'(1);
                    if (!ff_valid_q) begin
                        ff_x_d     = x_q;
                        ff_valid_d = 1'b1;
                    end
                end
                if (x_q == X_W'(15)) begin
                    // Completion outputs are launched here so they appear in DONE
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    oe_d    = 1'b0;
                    x_d     = '0;
                    pass_d  = (err_mask_d == '0);
                    state_d = DONE;
                end else begin
                    x_d     = x_q + X_W'(1);
                    state_d = DRIVE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort only acts on a running sweep; partial results are kept
        if (abort && (state_q == DRIVE || state_q == SAMPLE)) begin
            state_d    = IDLE;
            cnt_d      = '0;
            busy_d     = 1'b0;
            oe_d       = 1'b0;
            x_d        = '0;
            done_d     = 1'b0;
            pass_d     = 1'b0;
            err_mask_d = err_mask_q;
            fail_cnt_d = fail_cnt_q;
            ff_x_d     = ff_x_q;
            ff_valid_d = ff_valid_q;
        end
    end

    assign x                = x_q;
    assign oe               = oe_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign err_mask         = err_mask_q;
    assign fail_cnt         = fail_cnt_q;
    assign first_fail_x     = ff_x_q;
    assign first_fail_valid = ff_valid_q;

endmodule
